// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: debounces the start/stop and clear buttons,
// runs the IDLE/RUN/PAUSE/FULL state machine, keeps an SS.hh BCD count and
// produces the free-running scan clock and the pause blink enable.
module stopwatch_ctrl #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int SCAN_DIV  = 50_000,
  parameter int DEB_CNT   = 1_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [15:0] cntr,
  output logic        dispen,
  output logic        scan_clk,
  output logic        running,
  output logic        full
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);

  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CNT - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_FULL} state_t;

  state_t        state, state_next;
  logic [15:0]   cntr_next;
  logic [TW-1:0] presc, presc_next;
  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic [1:0]    raw, sync1, sync2, deb, deb_d, pulse;
  logic [DW-1:0] deb_cnt [2];
  logic          ss_p, clr_p, tick;

  // Bit 0 carries start/stop, bit 1 carries clear.
  assign raw   = {btn_clr, btn_ss};
  assign ss_p  = pulse[0];
  assign clr_p = pulse[1];
  assign tick  = (state == S_RUN) && (presc == TICK_MAX);

  // Adds one hundredth; every digit rolls over 9 -> 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Synchronize both buttons, accept a level only after DEB_CNT differing cycles, pulse on accepted rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      pulse <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      pulse <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DEB_MAX) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Next state, count and prescaler; clear overrides every other event.
  always_comb begin
    state_next = state;
    cntr_next  = cntr;
    presc_next = presc;
    if (clr_p) begin
      state_next = S_IDLE;
      cntr_next  = '0;
      presc_next = '0;
    end else begin
      case (state)
        S_IDLE:  if (ss_p) state_next = S_RUN;
        S_RUN: begin
          presc_next = tick ? '0 : presc + TW'(1);
          if (tick && (cntr == 16'h9999)) begin
            state_next = S_FULL;
          end else begin
            if (tick) cntr_next = bcd_inc(cntr);
            if (ss_p) state_next = S_PAUSE;
          end
        end
        S_PAUSE: if (ss_p) state_next = S_RUN;
        S_FULL:  state_next = S_FULL;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // State, count and the registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cntr    <= '0;
      presc   <= '0;
      running <= 1'b0;
      full    <= 1'b0;
    end else begin
      state   <= state_next;
      cntr    <= cntr_next;
      presc   <= presc_next;
      running <= (state_next == S_RUN);
      full    <= (state_next == S_FULL);
    end
  end

  // Blink the display while staying in PAUSE; any other state keeps it lit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      dispen    <= 1'b1;
    end else if ((state == S_PAUSE) && (state_next == S_PAUSE)) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_cnt <= '0;
        dispen    <= ~dispen;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blink_cnt <= '0;
      dispen    <= 1'b1;
    end
  end

  // Free-running scan clock, toggled every SCAN_DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_clk <= 1'b0;
    end else if (scan_cnt == SCAN_MAX) begin
      scan_cnt <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a cycle-level behavioural model (integer count,
// mode label, sample windows) checked every cycle, plus pinned literal checks.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int SCAN_DIV  = 2;
  localparam int DEB_CNT   = 3;
  localparam int BLINK_DIV = 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_FULL  = 3;
  localparam logic [7:0] WIN_MASK = 8'((1 << DEB_CNT) - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_ss = 1'b0;
  logic        btn_clr = 1'b0;
  logic [15:0] cntr;
  logic        dispen, scan_clk, running, full;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Model state
  int         m_mode = M_IDLE;
  int         m_count = 0;
  int         m_phase = 0;
  int         m_paused = 0;
  int         m_edges = 0;
  int         m_prev;
  logic [1:0] m_sync [2];
  logic [7:0] m_win [2];
  logic       m_deb [2];
  logic [1:0] m_ev [2];
  logic       m_raw [2];
  logic       m_fire [2];
  logic       m_in, m_rise, m_tick;

  stopwatch_ctrl #(
    .TICK_DIV (TICK_DIV),
    .SCAN_DIV (SCAN_DIV),
    .DEB_CNT  (DEB_CNT),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .cntr    (cntr),
    .dispen  (dispen),
    .scan_clk(scan_clk),
    .running (running),
    .full    (full)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic ss, input logic clr, input int cycles);
    btn_ss  = ss;
    btn_clr = clr;
    repeat (cycles) @(negedge clk);
  endtask

  // Behavioural model: raw -> 2-cycle delay -> accept after DEB_CNT differing samples -> act 2 edges later.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = M_IDLE; m_count = 0; m_phase = 0; m_paused = 0; m_edges = 0;
        for (int b = 0; b < 2; b++) begin
          m_sync[b] = '0; m_win[b] = '0; m_deb[b] = 1'b0; m_ev[b] = '0;
        end
      end else begin
        m_raw[0] = btn_ss;
        m_raw[1] = btn_clr;
        for (int b = 0; b < 2; b++) begin
          m_in      = m_sync[b][1];
          m_sync[b] = {m_sync[b][0], m_raw[b]};
          m_win[b]  = {m_win[b][6:0], m_in};
          m_fire[b] = m_ev[b][1];
          m_rise    = 1'b0;
          if ((m_win[b] & WIN_MASK) == (m_deb[b] ? 8'h00 : WIN_MASK)) begin
            m_deb[b] = ~m_deb[b];
            m_rise   = m_deb[b];
          end
          m_ev[b] = {m_ev[b][0], m_rise};
        end
        m_prev = m_mode;
        m_edges++;
        if (m_fire[1]) begin
          m_mode = M_IDLE; m_count = 0; m_phase = 0;
        end else if (m_mode == M_IDLE) begin
          if (m_fire[0]) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
          m_tick  = (m_phase == TICK_DIV - 1);
          m_phase = (m_phase + 1) % TICK_DIV;
          if (m_tick && m_count == 9999) m_mode = M_FULL;
          else begin
            if (m_tick) m_count++;
            if (m_fire[0]) m_mode = M_PAUSE;
          end
        end else if (m_mode == M_PAUSE) begin
          if (m_fire[0]) m_mode = M_RUN;
        end
        if (m_prev == M_PAUSE && m_mode == M_PAUSE) m_paused++;
        else m_paused = 0;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model_cntr", cntr, to_bcd(m_count));
      check_bit("model_running", running, m_mode == M_RUN);
      check_bit("model_full", full, m_mode == M_FULL);
      check_bit("model_dispen", dispen, (m_mode != M_PAUSE) || ((m_paused / BLINK_DIV) % 2 == 0));
      check_bit("model_scan_clk", scan_clk, ((m_edges / SCAN_DIV) % 2) == 1);
    end
  end

  // Guard against a hung run.
  initial begin
    #1_000_000;
    n_err++;
    $display("[TB] FAIL timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check_output("reset_cntr", cntr, 16'h0000);
    check_bit("reset_dispen", dispen, 1'b1);
    check_bit("reset_running", running, 1'b0);
    check_bit("reset_full", full, 1'b0);
    check_bit("reset_scan", scan_clk, 1'b0);
    rst = 1'b0;

    // A 2-cycle glitch must not be accepted
    apply_stimulus(1'b1, 1'b0, 2);
    apply_stimulus(1'b0, 1'b0, 15);
    check_bit("glitch_running", running, 1'b0);

    // Start, pause at 0x0012 with a partial tick, resume while blanked
    btn_ss = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      if (i == 10) btn_ss = 1'b0;
      if (i == 50) btn_ss = 1'b1;
      if (i == 60) btn_ss = 1'b0;
      if (i == 68) btn_ss = 1'b1;
      if (i == 78) btn_ss = 1'b0;
      case (i)
        6:  check_bit("run_latency_early", running, 1'b0);
        7:  check_bit("run_latency", running, 1'b1);
        10: check_output("first_tick_early", cntr, 16'h0000);
        11: check_output("first_tick", cntr, 16'h0001);
        47: check_output("cntr_0010", cntr, 16'h0010);
        57: begin
          check_bit("pause_running", running, 1'b0);
          check_output("pause_cntr", cntr, 16'h0012);
        end
        61: check_bit("blink_on", dispen, 1'b1);
        62: check_bit("blink_off", dispen, 1'b0);
        67: check_bit("blink_on_again", dispen, 1'b1);
        73: check_output("pause_hold", cntr, 16'h0012);
        74: check_bit("blink_off_before_resume", dispen, 1'b0);
        75: begin
          check_bit("resume_running", running, 1'b1);
          check_bit("resume_dispen", dispen, 1'b1);
        end
        76: check_output("resume_partial", cntr, 16'h0012);
        77: check_output("resume_tick", cntr, 16'h0013);
        default: ;
      endcase
    end

    apply_stimulus(1'b0, 1'b1, 10);
    apply_stimulus(1'b0, 1'b0, 10);
    check_output("clear_cntr", cntr, 16'h0000);
    check_bit("clear_running", running, 1'b0);

    // Tick at 0x0005 coincides with a start/stop pulse
    btn_ss = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (i == 10) btn_ss = 1'b0;
      if (i == 24) btn_ss = 1'b1;
      if (i == 34) btn_ss = 1'b0;
      case (i)
        30: check_output("pre_coincide_cntr", cntr, 16'h0005);
        31: begin
          check_output("coincide_cntr", cntr, 16'h0006);
          check_bit("coincide_running", running, 1'b0);
        end
        40: check_output("coincide_hold", cntr, 16'h0006);
        default: ;
      endcase
    end

    // Clear and start/stop together in PAUSE
    apply_stimulus(1'b1, 1'b1, 10);
    apply_stimulus(1'b0, 1'b0, 10);
    check_output("clr_ss_cntr", cntr, 16'h0000);
    check_bit("clr_ss_running", running, 1'b0);

    // Asynchronous reset in the middle of a run
    apply_stimulus(1'b1, 1'b0, 10);
    apply_stimulus(1'b0, 1'b0, 20);
    check_bit("pre_reset_running", running, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("async_rst_cntr", cntr, 16'h0000);
    check_bit("async_rst_dispen", dispen, 1'b1);
    check_bit("async_rst_running", running, 1'b0);
    check_bit("async_rst_scan", scan_clk, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check_bit("scan_period", scan_clk, ((i / 2) % 2) == 1);
    end

    // Randomized button activity
    for (int k = 0; k < 60; k++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), $urandom_range(1, 12));
    end

    apply_stimulus(1'b0, 1'b1, 10);
    apply_stimulus(1'b0, 1'b0, 10);

    // Long run through the 0x0999 carry up to FULL, then ignore start/stop
    btn_ss = 1'b1;
    for (int i = 1; i <= 40040; i++) begin
      @(negedge clk);
      if (i == 10) btn_ss = 1'b0;
      if (i == 40015) btn_ss = 1'b1;
      if (i == 40025) btn_ss = 1'b0;
      case (i)
        4003:  check_output("carry_pre", cntr, 16'h0999);
        4007:  check_output("carry", cntr, 16'h1000);
        40003: check_output("max_cntr", cntr, 16'h9999);
        40006: check_bit("full_early", full, 1'b0);
        40007: begin
          check_bit("full_set", full, 1'b1);
          check_bit("full_running", running, 1'b0);
          check_output("full_cntr", cntr, 16'h9999);
        end
        40040: begin
          check_bit("full_ignore_ss", full, 1'b1);
          check_output("full_hold_cntr", cntr, 16'h9999);
        end
        default: ;
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
